fetch_decode: RTL and testbench

Instruction fetch and decode sequencer that sits on the far side of the instruction ROM. It drives the 8-bit program counter into the ROM's address input and registers the returned 16-bit word. It splits the word into class, opcode, register and literal fields for the datapath control. It also handles the two-word LRLI instruction, branch redirects and pipeline stalls.

---
 rtl/fetch_decode.sv | 173 +++++++++++++++++
 tb/tb_fetch_decode.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_decode.sv
// Instruction fetch/decode sequencer: drives the ROM address, registers the returned
// word, splits it into datapath control fields and handles LRLI, branches and stalls.
module fetch_decode #(
  parameter int PC_W = 8,
  parameter int IW   = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [IW-1:0]   instr_in,
  input  logic            stall,
  input  logic            branch_en,
  input  logic [PC_W-1:0] branch_target,
  output logic [PC_W-1:0] pc,
  output logic            valid,
  output logic [1:0]      cls,
  output logic [4:0]      opcode,
  output logic            imm_form,
  output logic [2:0]      da,
  output logic [2:0]      aa,
  output logic [2:0]      ba,
  output logic [8:0]      imm,
  output logic [IW-1:0]   const_word,
  output logic            two_word
);

  typedef enum logic {FETCH = 1'b0, EXT = 1'b1} state_t;

  state_t state, state_next;

  // Handshake: there is no ready; valid is a one-cycle strobe per instruction unless
  // stall holds every output, in which case the same instruction stays presented.

  logic [1:0]      dec_cls;
  logic [4:0]      dec_opcode;
  logic            dec_imm_form;
  logic [2:0]      dec_da, dec_aa, dec_ba;
  logic [8:0]      dec_imm;
  logic            is_lrli;

  logic [PC_W-1:0] pc_n;
  logic            valid_n;
  logic [1:0]      cls_n;
  logic [4:0]      opcode_n;
  logic            imm_form_n;
  logic [2:0]      da_n, aa_n, ba_n;
  logic [8:0]      imm_n;
  logic [IW-1:0]   const_word_n;
  logic            two_word_n;

  // Field split of the incoming ROM word.
  always_comb begin
    dec_cls      = instr_in[15:14];
    dec_opcode   = 5'd0;
    dec_imm_form = 1'b0;
    dec_da       = 3'd0;
    dec_aa       = 3'd0;
    dec_ba       = 3'd0;
    dec_imm      = 9'd0;
    case (instr_in[15:14])
      2'b11: begin
        dec_opcode   = {3'b000, instr_in[13:12]};
        dec_da       = instr_in[11:9];
        dec_imm      = instr_in[8:0];
        dec_imm_form = 1'b1;
      end
      2'b01: begin
        dec_opcode = instr_in[13:9];
        dec_da     = instr_in[8:6];
        dec_aa     = instr_in[5:3];
        dec_ba     = instr_in[2:0];
      end
      default: begin
        if (instr_in[15:14] == 2'b00 || instr_in[13]) begin
          dec_opcode   = {2'b00, instr_in[13:11]};
          dec_da       = instr_in[10:8];
          dec_imm      = {1'b0, instr_in[7:0]};
          dec_imm_form = 1'b1;
        end else begin
          dec_opcode = instr_in[13:9];
          dec_da     = instr_in[8:6];
          dec_aa     = instr_in[5:3];
          dec_ba     = instr_in[2:0];
        end
      end
    endcase
  end

  assign is_lrli = (instr_in[15:14] == 2'b10) && (instr_in[13:9] == 5'b00010);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FETCH;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (branch_en) begin
      state_next = FETCH;
    end else if (!stall) begin
      case (state)
        FETCH:   state_next = is_lrli ? EXT : FETCH;
        EXT:     state_next = FETCH;
        default: state_next = FETCH;
      endcase
    end
  end

  // Next values of the registered outputs; default is to hold.
  always_comb begin
    pc_n         = pc;
    valid_n      = valid;
    cls_n        = cls;
    opcode_n     = opcode;
    imm_form_n   = imm_form;
    da_n         = da;
    aa_n         = aa;
    ba_n         = ba;
    imm_n        = imm;
    const_word_n = const_word;
    two_word_n   = two_word;
    if (branch_en) begin
      pc_n    = branch_target;
      valid_n = 1'b0;
    end else if (!stall) begin
      pc_n = pc + {{(PC_W-1){1'b0}}, 1'b1};
      if (state == FETCH) begin
        cls_n        = dec_cls;
        opcode_n     = dec_opcode;
        imm_form_n   = dec_imm_form;
        da_n         = dec_da;
        aa_n         = dec_aa;
        ba_n         = dec_ba;
        imm_n        = dec_imm;
        valid_n      = !is_lrli;
        const_word_n = '0;
        two_word_n   = 1'b0;
      end else begin
        const_word_n = instr_in;
        valid_n      = 1'b1;
        two_word_n   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc         <= '0;
      valid      <= 1'b0;
      cls        <= 2'd0;
      opcode     <= 5'd0;
      imm_form   <= 1'b0;
      da         <= 3'd0;
      aa         <= 3'd0;
      ba         <= 3'd0;
      imm        <= 9'd0;
      const_word <= '0;
      two_word   <= 1'b0;
    end else begin
      pc         <= pc_n;
      valid      <= valid_n;
      cls        <= cls_n;
      opcode     <= opcode_n;
      imm_form   <= imm_form_n;
      da         <= da_n;
      aa         <= aa_n;
      ba         <= ba_n;
      imm        <= imm_n;
      const_word <= const_word_n;
      two_word   <= two_word_n;
    end
  end

endmodule

// File: tb/tb_fetch_decode.sv
// Directed bench for fetch_decode: a behavioural ROM array feeds instr_in from pc,
// and every expected value below is worked out by hand from the instruction format.
module tb_fetch_decode;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] instr_in;
  logic        stall = 1'b0;
  logic        branch_en = 1'b0;
  logic [7:0]  branch_target = 8'd0;
  logic [7:0]  pc;
  logic        valid;
  logic [1:0]  cls;
  logic [4:0]  opcode;
  logic        imm_form;
  logic [2:0]  da, aa, ba;
  logic [8:0]  imm;
  logic [15:0] const_word;
  logic        two_word;

  logic [15:0] rom [256];
  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign instr_in = rom[pc];

  fetch_decode dut (
    .clk(clk), .rst(rst), .instr_in(instr_in), .stall(stall),
    .branch_en(branch_en), .branch_target(branch_target),
    .pc(pc), .valid(valid), .cls(cls), .opcode(opcode), .imm_form(imm_form),
    .da(da), .aa(aa), .ba(ba), .imm(imm), .const_word(const_word), .two_word(two_word)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and sample 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
    rom[8'h00] = 16'h0901;
    rom[8'h01] = 16'h6048;
    rom[8'h02] = 16'hD801;
    rom[8'h1E] = 16'h844A;
    rom[8'h1F] = 16'h0001;
    rom[8'h2D] = 16'hD801;
    rom[8'h40] = 16'h0000;
    rom[8'h41] = 16'hA5FF;
    rom[8'hFF] = 16'h844A;

    // Reset values
    step();
    chk("rst_pc", 16'(pc), 16'h00);
    chk("rst_valid", 16'(valid), 16'h0);
    chk("rst_cls", 16'(cls), 16'h0);
    chk("rst_opcode", 16'(opcode), 16'h0);
    chk("rst_imm_form", 16'(imm_form), 16'h0);
    chk("rst_const", const_word, 16'h0000);
    chk("rst_two_word", 16'(two_word), 16'h0);
    rst = 1'b0;

    // 0x0901: literal format
    step();
    chk("w0_pc", 16'(pc), 16'h01);
    chk("w0_valid", 16'(valid), 16'h1);
    chk("w0_cls", 16'(cls), 16'h0);
    chk("w0_opcode", 16'(opcode), 16'h01);
    chk("w0_da", 16'(da), 16'h1);
    chk("w0_imm", 16'(imm), 16'h001);
    chk("w0_imm_form", 16'(imm_form), 16'h1);
    chk("w0_aa", 16'(aa), 16'h0);

    // 0x6048: register format
    step();
    chk("w1_pc", 16'(pc), 16'h02);
    chk("w1_valid", 16'(valid), 16'h1);
    chk("w1_cls", 16'(cls), 16'h1);
    chk("w1_opcode", 16'(opcode), 16'h10);
    chk("w1_da", 16'(da), 16'h1);
    chk("w1_aa", 16'(aa), 16'h1);
    chk("w1_ba", 16'(ba), 16'h0);
    chk("w1_imm_form", 16'(imm_form), 16'h0);
    chk("w1_imm", 16'(imm), 16'h000);

    // Stall for three edges: everything frozen
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_pc", 16'(pc), 16'h02);
      chk("stall_valid", 16'(valid), 16'h1);
      chk("stall_opcode", 16'(opcode), 16'h10);
      chk("stall_da", 16'(da), 16'h1);
    end
    stall = 1'b0;

    // 0xD801: class 11 after stall release
    step();
    chk("w2_pc", 16'(pc), 16'h03);
    chk("w2_valid", 16'(valid), 16'h1);
    chk("w2_cls", 16'(cls), 16'h3);
    chk("w2_opcode", 16'(opcode), 16'h01);
    chk("w2_da", 16'(da), 16'h4);
    chk("w2_imm", 16'(imm), 16'h001);
    chk("w2_imm_form", 16'(imm_form), 16'h1);

    // Branch to LRLI at 0x1E
    branch_en = 1'b1; branch_target = 8'h1E;
    step();
    branch_en = 1'b0;
    chk("br1_pc", 16'(pc), 16'h1E);
    chk("br1_valid", 16'(valid), 16'h0);
    chk("br1_cls_hold", 16'(cls), 16'h3);
    step();
    chk("lrli1_pc", 16'(pc), 16'h1F);
    chk("lrli1_valid", 16'(valid), 16'h0);
    step();
    chk("lrli2_pc", 16'(pc), 16'h20);
    chk("lrli2_valid", 16'(valid), 16'h1);
    chk("lrli2_opcode", 16'(opcode), 16'h02);
    chk("lrli2_da", 16'(da), 16'h1);
    chk("lrli2_aa", 16'(aa), 16'h1);
    chk("lrli2_ba", 16'(ba), 16'h2);
    chk("lrli2_const", const_word, 16'h0001);
    chk("lrli2_two_word", 16'(two_word), 16'h1);

    // Branch while in EXT drops the extension
    branch_en = 1'b1; branch_target = 8'h1E;
    step();
    branch_en = 1'b0;
    step();
    chk("ext_pc", 16'(pc), 16'h1F);
    chk("ext_valid", 16'(valid), 16'h0);
    branch_en = 1'b1; branch_target = 8'h2D;
    step();
    branch_en = 1'b0;
    chk("brx_pc", 16'(pc), 16'h2D);
    chk("brx_valid", 16'(valid), 16'h0);
    step();
    chk("brx2_pc", 16'(pc), 16'h2E);
    chk("brx2_valid", 16'(valid), 16'h1);
    chk("brx2_cls", 16'(cls), 16'h3);
    chk("brx2_da", 16'(da), 16'h4);
    chk("brx2_const", const_word, 16'h0000);
    chk("brx2_two_word", 16'(two_word), 16'h0);

    // NOP word and class 10 literal format
    branch_en = 1'b1; branch_target = 8'h40;
    step();
    branch_en = 1'b0;
    step();
    chk("nop_valid", 16'(valid), 16'h1);
    chk("nop_cls", 16'(cls), 16'h0);
    chk("nop_opcode", 16'(opcode), 16'h00);
    chk("nop_imm", 16'(imm), 16'h000);
    step();
    chk("c10_cls", 16'(cls), 16'h2);
    chk("c10_opcode", 16'(opcode), 16'h04);
    chk("c10_da", 16'(da), 16'h5);
    chk("c10_imm", 16'(imm), 16'h0FF);
    chk("c10_imm_form", 16'(imm_form), 16'h1);
    chk("c10_pc", 16'(pc), 16'h42);

    // Wrap: LRLI at 0xFF, constant at 0x00
    rom[8'h00] = 16'h1234;
    branch_en = 1'b1; branch_target = 8'hFF;
    step();
    branch_en = 1'b0;
    step();
    chk("wrap1_pc", 16'(pc), 16'h00);
    chk("wrap1_valid", 16'(valid), 16'h0);
    step();
    chk("wrap2_pc", 16'(pc), 16'h01);
    chk("wrap2_valid", 16'(valid), 16'h1);
    chk("wrap2_const", const_word, 16'h1234);
    chk("wrap2_two_word", 16'(two_word), 16'h1);
    rom[8'h00] = 16'h0901;

    // Asynchronous reset while in EXT
    branch_en = 1'b1; branch_target = 8'h1E;
    step();
    branch_en = 1'b0;
    step();
    chk("pre_rst_pc", 16'(pc), 16'h1F);
    rst = 1'b1;
    #1;
    chk("arst_pc", 16'(pc), 16'h00);
    chk("arst_valid", 16'(valid), 16'h0);
    chk("arst_opcode", 16'(opcode), 16'h00);
    chk("arst_da", 16'(da), 16'h0);
    chk("arst_const", const_word, 16'h0000);
    chk("arst_two_word", 16'(two_word), 16'h0);
    step();
    rst = 1'b0;
    step();
    chk("post_rst_pc", 16'(pc), 16'h01);
    chk("post_rst_valid", 16'(valid), 16'h1);
    chk("post_rst_opcode", 16'(opcode), 16'h01);
    chk("post_rst_const", const_word, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
